// File: rtl/fetch_stage.sv
// Fetch stage and F/D pipeline register: PC selection, IM addressing,
// fetch address-error detection and delivery of instr/PC/BD/exccode to D.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter int unsigned IM_WORDS  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic        redirect_D,
  input  logic [31:0] npc_D,
  input  logic        eret_D,
  input  logic [31:0] epc,
  input  logic        exc_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        bd_D,
  output logic [4:0]  exccode_D
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned EXC_W  = 5;
  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  // One bit wider than the address so IM_BASE + 4*IM_WORDS cannot wrap.
  localparam logic [ADDR_W:0] IM_LIMIT = 33'(IM_BASE) + 33'(IM_WORDS) * 33'd4;

  logic              fetch_err;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] instr_next;
  logic [ADDR_W-1:0] pcd_next;
  logic              bd_next;
  logic [EXC_W-1:0]  exc_next;

  // IM address and D-stage return address are pure wiring.
  assign im_addr = pc_F;
  assign pc4_D   = pc_D + 32'd4;

  // Misaligned or outside the instruction memory window.
  always_comb begin
    fetch_err = 1'b0;
    if (pc_F[1:0] != 2'b00)              fetch_err = 1'b1;
    if (pc_F < IM_BASE)                  fetch_err = 1'b1;
    if ({1'b0, pc_F} >= IM_LIMIT)        fetch_err = 1'b1;
  end

  // Next PC and F/D contents by priority: exception, ERET, stall, redirect, sequential.
  always_comb begin
    pc_next    = pc_F + 32'd4;
    instr_next = fetch_err ? 32'h0 : im_rdata;
    pcd_next   = pc_F;
    bd_next    = redirect_D;
    exc_next   = fetch_err ? EXC_ADEL : EXC_NONE;
    if (exc_req) begin
      pc_next    = EXC_ENTRY;
      instr_next = 32'h0;
      pcd_next   = EXC_ENTRY;
      bd_next    = 1'b0;
      exc_next   = EXC_NONE;
    end else if (eret_D) begin
      pc_next    = epc;
      instr_next = 32'h0;
      pcd_next   = epc;
      bd_next    = 1'b0;
      exc_next   = EXC_NONE;
    end else if (stall_D) begin
      pc_next    = pc_F;
      instr_next = instr_D;
      pcd_next   = pc_D;
      bd_next    = bd_D;
      exc_next   = exccode_D;
    end else if (redirect_D) begin
      pc_next    = npc_D;
    end
  end

  // PC and F/D pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_F      <= PC_RESET;
      instr_D   <= 32'h0;
      pc_D      <= PC_RESET;
      bd_D      <= 1'b0;
      exccode_D <= EXC_NONE;
    end else begin
      pc_F      <= pc_next;
      instr_D   <= instr_next;
      pc_D      <= pcd_next;
      bd_D      <= bd_next;
      exccode_D <= exc_next;
    end
  end

endmodule
